// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter and its input synchronizer.
package period_meter_pkg;

    // Measurement state: waiting for a first edge, timing an interval, or
    // timed out because the counter ran out of range.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } meter_state_t;

    // Default counter width covers a 2^26 divide of the system clock.
    localparam int DEFAULT_COUNT_WIDTH = 27;

    // Two flops is the least that gives a usable metastability margin.
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int MIN_SYNC_STAGES     = 2;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Brings an asynchronous level into the clock domain and flags its rising
// edges. Reusable for any slow asynchronous input.
module sync_edge_detect
    import period_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    // Chains shorter than the minimum are stretched rather than rejected.
    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw input through the synchronizer, then keep one more copy
    // of the synchronized level so edges can be seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures the period of a slow square wave in system clock cycles.
// Reports edge-to-edge intervals with a valid strobe, tracks lock, and flags
// a stall when no edge arrives before the counter saturates.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   slow_in,
    output logic                   tick,
    output logic [COUNT_WIDTH-1:0] period,
    output logic                   period_valid,
    output logic                   locked,
    output logic                   stalled
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    meter_state_t           state;
    logic [COUNT_WIDTH-1:0] count;
    logic                   sync_level;
    logic                   sync_rise;

    // Saturating increment: the counter pins at its maximum, never wraps.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == COUNT_MAX) ? v : v + COUNT_ONE;
    endfunction

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .async_in(slow_in),
        .level   (sync_level),
        .rise    (sync_rise)
    );

    // A rise is only ever reported while the synchronized level is high.
    assign tick = sync_rise & sync_level;

    // Measurement state machine: counts clocks between ticks, publishes the
    // interval on each tick, and times out into STALLED at counter saturation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                // Disabling wins over any coincident tick; period is kept.
                state   <= IDLE;
                count   <= '0;
                locked  <= 1'b0;
                stalled <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        count   <= '0;
                        locked  <= 1'b0;
                        stalled <= 1'b0;
                        if (tick) begin
                            // First edge only opens the interval.
                            state <= MEASURE;
                            count <= COUNT_ONE;
                        end
                    end
                    MEASURE: begin
                        if (tick) begin
                            // A tick on the saturation cycle still reports.
                            period       <= count;
                            period_valid <= 1'b1;
                            locked       <= 1'b1;
                            count        <= COUNT_ONE;
                        end else if (count == COUNT_MAX) begin
                            state   <= STALLED;
                            stalled <= 1'b1;
                            locked  <= 1'b0;
                        end else begin
                            count <= sat_inc(count);
                        end
                    end
                    STALLED: begin
                        locked <= 1'b0;
                        if (tick) begin
                            // The overflowed interval is meaningless, so no
                            // valid; this edge restarts timing.
                            state   <= MEASURE;
                            count   <= COUNT_ONE;
                            stalled <= 1'b0;
                        end else begin
                            count   <= COUNT_MAX;
                            stalled <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        count   <= '0;
                        locked  <= 1'b0;
                        stalled <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: two instances (wide default counter and a 4-bit
// counter) share stimulus; both are compared every cycle against an
// interval-based reference model, with table entries and corner sequences.
module tb_period_meter;

    localparam int SS   = 2;
    localparam int MAXC = 8000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        slow_in = 1'b0;
    logic        tick_a, valid_a, locked_a, stalled_a;
    logic [26:0] period_a;
    logic        tick_b, valid_b, locked_b, stalled_b;
    logic [3:0]  period_b;

    period_meter #(.COUNT_WIDTH(27), .SYNC_STAGES(SS)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .slow_in(slow_in),
        .tick(tick_a), .period(period_a), .period_valid(valid_a),
        .locked(locked_a), .stalled(stalled_a)
    );

    period_meter #(.COUNT_WIDTH(4), .SYNC_STAGES(SS)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .slow_in(slow_in),
        .tick(tick_b), .period(period_b), .period_valid(valid_b),
        .locked(locked_b), .stalled(stalled_b)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int n = 0;
    int ph = 0;
    int vcnt_b = 0;
    int last_va = -1;
    int prev_va = -1;
    bit saw_stall_b = 0;

    // Input history, one entry per rising clock edge.
    bit hs[MAXC];
    bit he[MAXC];
    bit hr[MAXC];

    // Reference model state per instance (0: wide, 1: 4-bit).
    longint m_max[2];
    longint m_ref[2];
    longint m_period[2];
    bit     m_active[2];
    bit     m_locked[2];
    bit     m_stalled[2];
    bit     m_valid[2];

    typedef struct {
        int hi;
        int lo;
        int ncyc;
        int exp_period;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, n);
        end
    endtask

    // Synchronized level after edge k: the input seen SS-1 edges earlier,
    // forced low if a reset landed anywhere in that window.
    function automatic bit level_at(input int k);
        if (k - SS + 1 < 0) return 1'b0;
        for (int j = k - SS + 1; j <= k; j++)
            if (hr[j]) return 1'b0;
        return hs[k - SS + 1];
    endfunction

    function automatic bit tick_at(input int k);
        if (k < 0) return 1'b0;
        return level_at(k) & ~level_at(k - 1);
    endfunction

    // Model step for edge k, working from elapsed edges since the last
    // accepted rising edge rather than from a counter.
    task automatic model_step(input int i, input int k);
        bit tk;
        longint el;
        tk = tick_at(k - 1);
        m_valid[i] = 1'b0;
        if (hr[k]) begin
            m_active[i] = 0; m_locked[i] = 0; m_stalled[i] = 0; m_period[i] = 0;
        end else if (!he[k]) begin
            m_active[i] = 0; m_locked[i] = 0; m_stalled[i] = 0;
        end else if (!m_active[i]) begin
            if (tk) begin
                m_active[i] = 1;
                m_ref[i] = k;
            end
        end else begin
            el = k - m_ref[i];
            if (tk) begin
                if (!m_stalled[i]) begin
                    m_period[i] = el;
                    m_valid[i] = 1'b1;
                    m_locked[i] = 1'b1;
                end
                m_ref[i] = k;
                m_stalled[i] = 1'b0;
            end else if (!m_stalled[i] && el >= m_max[i]) begin
                m_stalled[i] = 1'b1;
                m_locked[i] = 1'b0;
            end
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // One clock: apply inputs, advance, then compare both instances.
    task automatic cyc(input bit s, input bit en, input bit rs);
        slow_in = s;
        enable = en;
        reset = rs;
        @(posedge clock);
        hs[n] = s; he[n] = en; hr[n] = rs;
        #1;
        model_step(0, n);
        model_step(1, n);
        chk("tick_a", tick_a, tick_at(n));
        chk("valid_a", valid_a, m_valid[0]);
        chk("period_a", period_a, m_period[0]);
        chk("locked_a", locked_a, m_locked[0]);
        chk("stalled_a", stalled_a, m_stalled[0]);
        chk("tick_b", tick_b, tick_at(n));
        chk("valid_b", valid_b, m_valid[1]);
        chk("period_b", period_b, m_period[1]);
        chk("locked_b", locked_b, m_locked[1]);
        chk("stalled_b", stalled_b, m_stalled[1]);
        if (stalled_b) saw_stall_b = 1;
        if (valid_b) vcnt_b++;
        if (valid_a) begin
            prev_va = last_va;
            last_va = n;
        end
        n++;
        if (n >= MAXC) begin
            failures++;
            $display("FAIL cycle_budget actual=%0d limit=%0d", n, MAXC);
            finish_run();
        end
    endtask

    // Square wave with hi/lo cycle counts, optional one-cycle reset at
    // rs_at and enable low for en_len cycles starting at en_from.
    task automatic wave(input int hi, input int lo, input int ncyc,
                        input int rs_at, input int en_from, input int en_len);
        bit s, en;
        ph = ph % (hi + lo);
        for (int c = 0; c < ncyc; c++) begin
            s = (ph < hi);
            ph = ph + 1;
            if (ph >= hi + lo) ph = 0;
            en = !(c >= en_from && c < en_from + en_len);
            cyc(s, en, c == rs_at);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, lo, len, rs_at, en_from, en_len;
        m_max[0] = (64'd1 << 27) - 1;
        m_max[1] = 15;
        for (int i = 0; i < 2; i++) begin
            m_ref[i] = 0; m_period[i] = 0; m_active[i] = 0;
            m_locked[i] = 0; m_stalled[i] = 0; m_valid[i] = 0;
        end
        tbl[0] = '{4, 4, 80, 8};
        tbl[1] = '{1, 1, 40, 2};
        tbl[2] = '{2, 5, 70, 7};
        tbl[3] = '{10, 10, 120, 20};
        tbl[4] = '{3, 12, 100, 15};
        tbl[5] = '{1, 2, 40, 3};

        // Reset state
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("rst_period", period_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_locked", locked_a, 0);
        chk("rst_stalled", stalled_a, 0);
        chk("rst_tick", tick_a, 0);
        cyc(0, 1, 0);

        // Steady square waves from the table
        for (int t = 0; t < 6; t++) begin
            ph = 0;
            last_va = -1;
            prev_va = -1;
            wave(tbl[t].hi, tbl[t].lo, tbl[t].ncyc, -1, tbl[t].ncyc, 0);
            chk("tbl_period", period_a, tbl[t].exp_period);
            chk("tbl_locked", locked_a, 1);
            chk("tbl_spacing", last_va - prev_va, tbl[t].exp_period);
        end

        // 4-bit counter: one edge then silence runs into a stall
        for (int i = 0; i < 10; i++) cyc(0, 1, 0);
        cyc(1, 1, 0);
        for (int i = 0; i < 30; i++) cyc(0, 1, 0);
        chk("stall_b_set", stalled_b, 1);
        chk("stall_b_locked", locked_b, 0);
        chk("stall_a_clear", stalled_a, 0);
        vcnt_b = 0;
        cyc(1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        cyc(1, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0);
        chk("unstall_valids", vcnt_b, 1);
        chk("unstall_period", period_b, 5);
        chk("unstall_stalled", stalled_b, 0);

        // Edge exactly on the saturation cycle of the 4-bit counter
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        saw_stall_b = 0;
        vcnt_b = 0;
        cyc(1, 1, 0);
        for (int i = 0; i < 14; i++) cyc(0, 1, 0);
        cyc(1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        chk("sat_period_b", period_b, 15);
        chk("sat_no_stall", saw_stall_b, 0);
        chk("sat_valids", vcnt_b, 2);
        chk("sat_period_a", period_a, 15);

        // Reset midway through a 20-cycle period
        ph = 0;
        wave(10, 10, 65, -1, 65, 0);
        wave(10, 10, 1, 0, 1, 0);
        chk("midrst_period", period_a, 0);
        chk("midrst_valid", valid_a, 0);
        chk("midrst_locked", locked_a, 0);
        chk("midrst_stalled", stalled_a, 0);
        chk("midrst_tick", tick_a, 0);
        chk("midrst_locked_b", locked_b, 0);
        wave(10, 10, 60, -1, 60, 0);
        chk("postrst_period", period_a, 20);
        chk("postrst_locked", locked_a, 1);

        // Enable dropped for 3 cycles while locked at period 10
        ph = 0;
        wave(5, 5, 50, -1, 50, 0);
        chk("pre_en_period", period_a, 10);
        wave(5, 5, 3, -1, 0, 3);
        chk("en_off_locked", locked_a, 0);
        chk("en_off_period", period_a, 10);
        chk("en_off_stalled", stalled_a, 0);
        wave(5, 5, 30, -1, 30, 0);
        chk("reen_period", period_a, 10);
        chk("reen_locked", locked_a, 1);

        // Randomized segments against the model
        for (int seg = 0; seg < 40; seg++) begin
            hi = $urandom_range(1, 20);
            lo = $urandom_range(1, 20);
            len = $urandom_range(10, 120);
            rs_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
            en_from = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : len;
            en_len = $urandom_range(1, 6);
            wave(hi, lo, len, rs_at, en_from, en_len);
        end

        finish_run();
    end

endmodule
